fp_add_seq: RTL and testbench



---
 rtl/fp32_pkg.sv | 14 +
 rtl/fp_lzc27.sv | 10 +
 rtl/fp_add_seq.sv | 167 ++++++++++++++++
 tb/tb_fp_add_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared widths, constants, FSM states and field struct for the fp32 adder
package fp32_pkg;
  localparam int BIAS = 127;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [30:0] MAXFIN = 31'h7F7F_FFFF;
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;
endpackage

// File: rtl/fp_lzc27.sv
// fp_lzc27: leading-zero count of a 27-bit mantissa (27 when all zero)
module fp_lzc27 (
  input  logic [26:0] x,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < 27; i++) if (x[i]) cnt = 5'(26 - i);
  end
endmodule

// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle fp32 add/sub with RNE and FTZ; define FP_SPECIAL_EN to decode Inf/NaN
module fp_add_seq #(
  parameter int BIAS = 127,
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        zero
);
  import fp32_pkg::*;
  localparam int EMAX = 2 * BIAS + 1;
  state_t state_q, state_d;
  fp32_t a_q, a_d, b_q, b_d, big, lit;
  logic sign_q, sign_d, sub_q, sub_d, zf_q, zf_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [9:0] exp_q, exp_d, er;
  logic [7:0] sh_q, sh_d;
  logic [23:0] m0_q, m0_d;
  logic [26:0] m1_q, m1_d;
  logic [27:0] man_q, man_d, m0x, nrm;
  logic [31:0] result_q, result_d, res_n;
  logic za, zb, swap, zbig, zlit, inc, ov, ovf_n, zero_n;
  logic [52:0] al_w;
  logic [4:0] lz;
  logic [24:0] rnd;
  logic [22:0] fr;
  fp_lzc27 u_lzc (.x(man_q[26:0]), .cnt(lz));
  assign za = a_q.exp == '0;
  assign zb = b_q.exp == '0;
  assign swap = (zb ? 31'd0 : b_q[30:0]) > (za ? 31'd0 : a_q[30:0]);
  assign big = swap ? b_q : a_q;
  assign lit = swap ? a_q : b_q;
  assign zbig = swap ? zb : za;
  assign zlit = swap ? za : zb;
  assign al_w = {m1_q[26:3], 29'd0} >> (sh_q[7:5] != 3'd0 ? 5'd31 : sh_q[4:0]);
  assign m0x = {1'b0, m0_q, 3'd0};
  assign nrm = man_q << lz;
  assign inc = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
  assign rnd = {1'b0, man_q[26:3]} + {24'd0, inc};
  assign er = exp_q + {9'd0, rnd[24]};
  assign fr = rnd[24] ? rnd[23:1] : rnd[22:0];
  assign ov = er >= 10'(EMAX);
`ifdef FP_SPECIAL_EN
  logic ia, ib, nan;
  assign ia = a_q.exp == '1;
  assign ib = b_q.exp == '1;
  assign nan = (ia && a_q.frac != '0) || (ib && b_q.frac != '0) || (ia && ib && a_q.sign != b_q.sign);
  assign res_n = nan ? QNAN : ia ? {a_q.sign, 8'hFF, 23'd0} : ib ? {b_q.sign, 8'hFF, 23'd0} :
                 zf_q ? {sign_q, 31'd0} : ov ? {sign_q, 8'hFF, 23'd0} : {sign_q, er[7:0], fr};
  assign ovf_n = !(ia || ib) && !zf_q && ov;
  assign zero_n = !(ia || ib) && zf_q;
`else
  assign res_n = zf_q ? {sign_q, 31'd0} : ov ? {sign_q, MAXFIN} : {sign_q, er[7:0], fr};
  assign ovf_n = !zf_q && ov;
  assign zero_n = zf_q;
`endif
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sign_d = sign_q;
    sub_d = sub_q;
    exp_d = exp_q;
    sh_d = sh_q;
    m0_d = m0_q;
    m1_d = m1_q;
    man_d = man_q;
    zf_d = zf_q;
    result_d = result_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = {b[31] ^ sub, b[30:0]};
        state_d = UNPACK;
      end
      UNPACK: begin
        sign_d = big.sign;
        sub_d = big.sign ^ lit.sign;
        exp_d = {2'b0, big[FRAC_W +: EXP_W]};
        m0_d = zbig ? '0 : {1'b1, big[FRAC_W-1:0]};
        m1_d = {zlit ? 24'd0 : {1'b1, lit.frac}, 3'd0};
        sh_d = big.exp - lit.exp;
        state_d = ALIGN;
      end
      ALIGN: begin
        m1_d = {al_w[52:27], |al_w[26:0]};
        state_d = ADD;
      end
      ADD: begin
        man_d = sub_q ? m0x - {1'b0, m1_q} : m0x + {1'b0, m1_q};
        state_d = NORM;
      end
      NORM: begin
        state_d = ROUND;
        zf_d = 1'b0;
        if (man_q[27]) begin
          man_d = {1'b0, man_q[27:2], man_q[1] | man_q[0]};
          exp_d = exp_q + 10'd1;
        end else if (man_q == '0 || exp_q <= {5'd0, lz}) begin
          // exact cancellation of opposite signs yields +0; underflow keeps the sign
          man_d = '0;
          zf_d = 1'b1;
          sign_d = sign_q & !(man_q == '0 && sub_q);
        end else begin
          man_d = nrm;
          exp_d = exp_q - {5'd0, lz};
        end
      end
      ROUND: begin
        result_d = res_n;
        ovf_d = ovf_n;
        zero_d = zero_n;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sign_q <= 1'b0;
      sub_q <= 1'b0;
      exp_q <= '0;
      sh_q <= '0;
      m0_q <= '0;
      m1_q <= '0;
      man_q <= '0;
      zf_q <= 1'b0;
      result_q <= '0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sign_q <= sign_d;
      sub_q <= sub_d;
      exp_q <= exp_d;
      sh_q <= sh_d;
      m0_q <= m0_d;
      m1_q <= m1_d;
      man_q <= man_d;
      zf_q <= zf_d;
      result_q <= result_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign ovf = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: directed vectors checked against an exact-arithmetic reference model
`timescale 1ns/1ps
module tb_fp_add_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, sub = 0, out_ready = 1;
  logic [31:0] a = 0, b = 0, result;
  logic in_ready, out_valid, ovf, zero;
  int tests = 0, fails = 0, cyc = 0, acc_cyc = 0;
  logic pending = 0, seen = 0;
  logic [39:0] expv = 0;
`ifdef FP_SPECIAL_EN
  localparam logic [31:0] OVR = 32'h7F80_0000;
`else
  localparam logic [31:0] OVR = 32'h7F7F_FFFF;
`endif
  fp_add_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf), .zero(zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (out_valid && out_ready) pending = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // returns {ovf, zero, result}; values are integers in units of 2^-149
  function automatic logic [39:0] model(input logic [31:0] x, input logic [31:0] y0, input logic s);
    logic [31:0] y;
    logic [279:0] vx, vy, mag, rem, half, one;
    logic sg;
    logic [24:0] keep;
    int p, e, sh;
    y = {y0[31] ^ s, y0[30:0]};
`ifdef FP_SPECIAL_EN
    if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0) ||
        (x[30:23] == 8'hFF && y[30:23] == 8'hFF && x[31] != y[31])) return {8'h00, 32'h7FC0_0000};
    if (x[30:23] == 8'hFF) return {8'h00, x[31], 8'hFF, 23'd0};
    if (y[30:23] == 8'hFF) return {8'h00, y[31], 8'hFF, 23'd0};
`endif
    vx = x[30:23] == 0 ? '0 : 280'({1'b1, x[22:0]}) << (x[30:23] - 8'd1);
    vy = y[30:23] == 0 ? '0 : 280'({1'b1, y[22:0]}) << (y[30:23] - 8'd1);
    if (x[31] == y[31]) begin mag = vx + vy; sg = x[31]; end
    else if (vx >= vy) begin mag = vx - vy; sg = (vx == vy) ? 1'b0 : x[31]; end
    else begin mag = vy - vx; sg = y[31]; end
    if (mag == 0) return {8'h01, sg, 31'd0};
    p = 0;
    for (int i = 0; i < 280; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e < 1) return {8'h01, sg, 31'd0};
    sh = p - 23;
    keep = 25'(mag >> sh);
    if (sh > 0) begin
      one = 280'd1;
      rem = mag & ((one << sh) - one);
      half = one << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 25'd1;
    end
    if (keep[24]) begin keep = keep >> 1; e++; end
    if (e >= 255) return {8'h02, sg, OVR[30:0]};
    return {8'h00, sg, 8'(e), keep[22:0]};
  endfunction

  always @(negedge clk) if (rst_n && out_valid) begin
    if (!pending) chk("spurious_valid", 40'(out_valid), 40'd0);
    else begin
      if (!seen) begin
        chk("latency", 40'(cyc - acc_cyc), 40'd5);
        seen = 1;
      end
      chk("result", {6'd0, ovf, zero, result}, expv);
      chk("in_ready_busy", 40'(in_ready), 40'd0);
    end
  end

  task automatic start(input logic [31:0] x, input logic [31:0] y, input logic s, input logic [39:0] lit);
    chk("model_pin", model(x, y, s), lit);
    @(negedge clk);
    chk("in_ready_idle", 40'(in_ready), 40'd1);
    a = x; b = y; sub = s; in_valid = 1;
    @(posedge clk); #1;
    acc_cyc = cyc; expv = model(x, y, s); pending = 1; seen = 0; in_valid = 0;
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s, input logic [39:0] lit, input int hold);
    out_ready = (hold == 0);
    start(x, y, s, lit);
    if (hold == 0) begin
      for (int i = 0; i < 30 && pending; i++) @(negedge clk);
      chk("done_timeout", 40'(pending), 40'd0);
      pending = 0;
    end else begin
      a = 32'h1234_5678; b = 32'h4000_0000; in_valid = 1;
      for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
      chk("valid_timeout", 40'(out_valid), 40'd1);
      repeat (hold) @(negedge clk);
      in_valid = 0; out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      chk("in_ready_rise", {38'd0, in_ready, out_valid}, 40'b10);
      pending = 0;
    end
  endtask

  initial begin
    #12;
    chk("reset_state", {4'd0, in_ready, out_valid, ovf, zero, result}, {4'd0, 4'b1000, 32'd0});
    @(negedge clk); rst_n = 1;
    run_op(32'h34AA724D, 32'h29D5DF3B, 0, {8'h00, 32'h34AA7250}, 0);
    run_op(32'hA64BAB24, 32'h9F545195, 0, {8'h00, 32'hA64BAE75}, 0);
    run_op(32'hD8817676, 32'hE386DF4E, 0, {8'h00, 32'hE386DF50}, 0);
    run_op(32'h3F800000, 32'h3F800000, 1, {8'h01, 32'h00000000}, 0);
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 0, {8'h02, OVR}, 0);
    run_op(32'h3F800000, 32'h00000000, 0, {8'h00, 32'h3F800000}, 0);
    run_op(32'h80000000, 32'h80000000, 0, {8'h01, 32'h80000000}, 0);
    run_op(32'h00400000, 32'h3F800000, 0, {8'h00, 32'h3F800000}, 0);
    run_op(32'h3F800000, 32'h33800000, 0, {8'h00, 32'h3F800000}, 0);
    run_op(32'h3F800001, 32'h33800000, 0, {8'h00, 32'h3F800002}, 0);
    run_op(32'h3F800000, 32'h3FC00000, 1, {8'h00, 32'hBF000000}, 0);
    run_op(32'h3F800000, 32'h00800000, 0, {8'h00, 32'h3F800000}, 0);
    run_op(32'h00C00000, 32'h00800000, 1, {8'h01, 32'h00000000}, 0);
    run_op(32'hBF800000, 32'h3F800000, 0, {8'h01, 32'h00000000}, 0);
    run_op(32'h3F800000, 32'h40000000, 0, {8'h00, 32'h40400000}, 10);
    out_ready = 1;
    start(32'h3F800000, 32'h3F800000, 0, {8'h00, 32'h40000000});
    @(posedge clk); #1;
    rst_n = 0; #1;
    chk("abort_align", {38'd0, out_valid, in_ready}, 40'b01);
    pending = 0;
    @(negedge clk); rst_n = 1;
    repeat (8) @(negedge clk);
    run_op(32'h40000000, 32'h40000000, 0, {8'h00, 32'h40800000}, 0);
    out_ready = 0;
    start(32'h40400000, 32'h3F800000, 0, {8'h00, 32'h40800000});
    for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
    #2 rst_n = 0; #1;
    chk("abort_done", {38'd0, out_valid, in_ready}, 40'b01);
    pending = 0;
    @(negedge clk); rst_n = 1; out_ready = 1;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
